// File: rtl/sdram_pkg.sv
// Shared SDRAM controller types and timing constants used by the init sequencer,
// the command arbiter and the command engines.
package sdram_pkg;

  // tREFI = 7.8 us at 100 MHz (8192 rows every 64 ms)
  localparam int unsigned T_REFI_CYC = 780;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REF  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REF  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } grant_e;

  // Round-robin between the two user ports when both are asking.
  function automatic grant_e pick_user(logic wr, logic rd, grant_e last);
    if (wr && rd) return (last == GNT_WR) ? GNT_RD : GNT_WR;
    if (wr)       return GNT_WR;
    if (rd)       return GNT_RD;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises a sticky refresh request every REF_PERIOD
// cycles while the SDRAM is initialised, and flags a missed refresh.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = T_REFI_CYC,
  parameter int CNT_W      = 10
) (
  input  logic REF_CLK,
  input  logic RST,
  input  logic INIT_DONE,
  input  logic clr,
  output logic ref_req,
  output logic overrun
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = INIT_DONE && (cnt == CNT_W'(REF_PERIOD - 1));

  always_ff @(posedge REF_CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      ref_req <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!INIT_DONE || wrap) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
      // A wrap coinciding with the grant of the old request is a fresh request, not a miss.
      if (wrap)     ref_req <= 1'b1;
      else if (clr) ref_req <= 1'b0;
      if (wrap && ref_req && !clr) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Bank-command slot owner after init: arbitrates refresh > write/read (round-robin)
// and hands one operation at a time to its engine via level-enable / done-pulse.
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = T_REFI_CYC,
  parameter int CNT_W      = 10
) (
  input  logic REF_CLK,
  input  logic RST,
  input  logic INIT_DONE,
  input  logic WR_REQ,
  input  logic RD_REQ,
  output logic WR_ACK,
  output logic RD_ACK,
  output logic REF_EN,
  output logic WR_EN,
  output logic RD_EN,
  input  logic REF_DONE,
  input  logic WR_DONE,
  input  logic RD_DONE,
  output logic REF_OVERRUN
);

  arb_state_e state;
  grant_e     last_grant;
  logic       ref_req;
  logic       ref_clr;

  // Refresh is taken on exactly the edge where IDLE sees a pending request.
  assign ref_clr = (state == ST_IDLE) && INIT_DONE && ref_req;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_ref_timer (
    .REF_CLK   (REF_CLK),
    .RST       (RST),
    .INIT_DONE (INIT_DONE),
    .clr       (ref_clr),
    .ref_req   (ref_req),
    .overrun   (REF_OVERRUN)
  );

  always_ff @(posedge REF_CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      last_grant <= GNT_RD;
      REF_EN     <= 1'b0;
      WR_EN      <= 1'b0;
      RD_EN      <= 1'b0;
      WR_ACK     <= 1'b0;
      RD_ACK     <= 1'b0;
    end else begin
      WR_ACK <= 1'b0;
      RD_ACK <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (INIT_DONE) begin
            if (ref_req) begin
              state  <= ST_REF;
              REF_EN <= 1'b1;
            end else begin
              case (pick_user(WR_REQ, RD_REQ, last_grant))
                GNT_WR: begin
                  state      <= ST_WR;
                  WR_EN      <= 1'b1;
                  WR_ACK     <= 1'b1;
                  last_grant <= GNT_WR;
                end
                GNT_RD: begin
                  state      <= ST_RD;
                  RD_EN      <= 1'b1;
                  RD_ACK     <= 1'b1;
                  last_grant <= GNT_RD;
                end
                default: ;
              endcase
            end
          end
        end
        ST_REF: if (REF_DONE) begin
          state  <= ST_IDLE;
          REF_EN <= 1'b0;
        end
        ST_WR: if (WR_DONE) begin
          state <= ST_IDLE;
          WR_EN <= 1'b0;
        end
        ST_RD: if (RD_DONE) begin
          state <= ST_IDLE;
          RD_EN <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Bench for sdram_cmd_arbiter: table vectors, directed corner sequences and random
// traffic, all scored against a behavioural model of the arbitration rules.
module tb_sdram_cmd_arbiter;

  localparam int RP = 780;

  logic REF_CLK = 1'b0;
  logic RST, INIT_DONE, WR_REQ, RD_REQ, REF_DONE, WR_DONE, RD_DONE;
  logic WR_ACK, RD_ACK, REF_EN, WR_EN, RD_EN, REF_OVERRUN;
  logic [5:0] outs;

  always #5 REF_CLK = ~REF_CLK;

  assign outs = {REF_OVERRUN, REF_EN, WR_EN, RD_EN, WR_ACK, RD_ACK};

  sdram_cmd_arbiter dut (
    .REF_CLK     (REF_CLK),
    .RST         (RST),
    .INIT_DONE   (INIT_DONE),
    .WR_REQ      (WR_REQ),
    .RD_REQ      (RD_REQ),
    .WR_ACK      (WR_ACK),
    .RD_ACK      (RD_ACK),
    .REF_EN      (REF_EN),
    .WR_EN       (WR_EN),
    .RD_EN       (RD_EN),
    .REF_DONE    (REF_DONE),
    .WR_DONE     (WR_DONE),
    .RD_DONE     (RD_DONE),
    .REF_OVERRUN (REF_OVERRUN)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: op 0=none 1=refresh 2=write 3=read
  int m_run;
  int m_op;
  int m_age;
  bit m_pend, m_ovr, m_last_wr, m_wack, m_rack;

  bit auto_done, auto_req, noise;
  int dly_ref, dly_wr, dly_rd;

  typedef struct packed {
    logic [5:0] stim;  // {INIT_DONE, WR_REQ, RD_REQ, REF_DONE, WR_DONE, RD_DONE}
    logic [5:0] exp;   // {REF_OVERRUN, REF_EN, WR_EN, RD_EN, WR_ACK, RD_ACK}
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] m_out();
    return {m_ovr, m_op == 1, m_op == 2, m_op == 3, m_wack, m_rack};
  endfunction

  task automatic model_reset();
    m_run = 0; m_op = 0; m_age = 0;
    m_pend = 0; m_ovr = 0; m_last_wr = 0; m_wack = 0; m_rack = 0;
  endtask

  task automatic model_step();
    bit wrap, gref;
    // Interval ends on every RP-th consecutive edge with INIT_DONE high.
    wrap = INIT_DONE && ((m_run + 1) % RP == 0);
    gref = 0;
    m_wack = 0;
    m_rack = 0;
    if (m_op == 0) begin
      if (INIT_DONE) begin
        if (m_pend) begin m_op = 1; gref = 1; end
        else if (WR_REQ && (!RD_REQ || !m_last_wr)) begin m_op = 2; m_wack = 1; m_last_wr = 1; end
        else if (RD_REQ) begin m_op = 3; m_rack = 1; m_last_wr = 0; end
        m_age = 1;
      end
    end else if ((m_op == 1 && REF_DONE) || (m_op == 2 && WR_DONE) || (m_op == 3 && RD_DONE)) begin
      m_op = 0;
    end else begin
      m_age++;
    end
    if (wrap && m_pend && !gref) m_ovr = 1;
    if (wrap) m_pend = 1;
    else if (gref) m_pend = 0;
    m_run = INIT_DONE ? m_run + 1 : 0;
  endtask

  // One clock: drive engine responses, advance model at the edge, score at negedge.
  task automatic tick();
    if (auto_done) begin
      REF_DONE = (m_op == 1 && m_age == dly_ref);
      WR_DONE  = (m_op == 2 && m_age == dly_wr);
      RD_DONE  = (m_op == 3 && m_age == dly_rd);
      if (noise) begin
        REF_DONE = REF_DONE | ($urandom_range(0, 31) == 0);
        WR_DONE  = WR_DONE  | ($urandom_range(0, 31) == 0);
        RD_DONE  = RD_DONE  | ($urandom_range(0, 31) == 0);
      end
    end
    @(posedge REF_CLK);
    if (!RST) model_step();
    cyc++;
    @(negedge REF_CLK);
    check("outputs_vs_model", 32'(outs), 32'(m_out()));
    if (auto_req) begin
      if (m_wack) WR_REQ = 0;
      if (m_rack) RD_REQ = 0;
    end
  endtask

  task automatic do_reset();
    RST = 1; INIT_DONE = 0; WR_REQ = 0; RD_REQ = 0;
    REF_DONE = 0; WR_DONE = 0; RD_DONE = 0;
    auto_done = 0; auto_req = 0; noise = 0;
    dly_ref = 4; dly_wr = 3; dly_rd = 3;
    model_reset();
    repeat (2) @(negedge REF_CLK);
    check("reset_outputs", 32'(outs), 32'h0);
    RST = 0;
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rq[$], fq[$], acks[$];
    logic pr;
    int first_rise;

    tbl[0]  = '{6'b111000, 6'b001010};
    tbl[1]  = '{6'b101000, 6'b001000};
    tbl[2]  = '{6'b101010, 6'b000000};
    tbl[3]  = '{6'b111000, 6'b000101};
    tbl[4]  = '{6'b110010, 6'b000100};
    tbl[5]  = '{6'b110001, 6'b000000};
    tbl[6]  = '{6'b111000, 6'b001010};
    tbl[7]  = '{6'b101100, 6'b001000};
    tbl[8]  = '{6'b101010, 6'b000000};
    tbl[9]  = '{6'b001000, 6'b000000};
    tbl[10] = '{6'b011000, 6'b000000};
    tbl[11] = '{6'b101000, 6'b000101};
    tbl[12] = '{6'b100001, 6'b000000};
    tbl[13] = '{6'b110000, 6'b001010};
    tbl[14] = '{6'b100010, 6'b000000};

    // Table vectors: arbitration, round-robin, ignored mismatched DONEs, INIT_DONE gating
    do_reset();
    for (int i = 0; i < 15; i++) begin
      {INIT_DONE, WR_REQ, RD_REQ, REF_DONE, WR_DONE, RD_DONE} = tbl[i].stim;
      tick();
      check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
    end

    // Not initialised: requests held high get nothing
    do_reset();
    WR_REQ = 1; RD_REQ = 1;
    pr = 0;
    repeat (2000) begin
      tick();
      pr = pr | REF_EN | WR_EN | RD_EN | WR_ACK | RD_ACK;
    end
    check("no_init_no_grant", 32'(pr), 32'h0);
    check("no_init_overrun", 32'(REF_OVERRUN), 32'h0);

    // Periodic refresh spacing and pulse width
    do_reset();
    INIT_DONE = 1; auto_done = 1;
    rq.delete(); fq.delete();
    repeat (2400) begin
      pr = REF_EN;
      tick();
      if (REF_EN && !pr) rq.push_back(cyc);
      if (!REF_EN && pr) fq.push_back(cyc);
    end
    check("ref_rise_count", 32'(rq.size()), 32'd3);
    if (rq.size() > 0) check("ref_first_rise", 32'(rq[0]), 32'd781);
    for (int i = 0; i < rq.size(); i++) begin
      if (i > 0) check("ref_spacing", 32'(rq[i] - rq[i-1]), 32'd780);
      if (i < fq.size()) check("ref_width", 32'(fq[i] - rq[i]), 32'd4);
    end

    // Refresh and write pending in the same IDLE cycle: refresh first
    do_reset();
    INIT_DONE = 1; auto_done = 1; auto_req = 1;
    repeat (780) tick();
    WR_REQ = 1;
    tick();
    check("ref_before_wr", 32'({REF_EN, WR_ACK}), 32'b10);
    for (int i = 0; i < 20 && REF_EN; i++) tick();
    check("ref_fell", 32'(REF_EN), 32'h0);
    tick();
    check("wr_ack_after_ref", 32'({WR_ACK, WR_EN}), 32'b11);

    // Both users held: strict W,R,W,R alternation, ACK with EN
    do_reset();
    INIT_DONE = 1; auto_done = 1; WR_REQ = 1; RD_REQ = 1;
    acks.delete();
    repeat (30) begin
      tick();
      if (WR_ACK) begin acks.push_back(0); check("wr_ack_with_en", 32'(WR_EN), 32'h1); end
      if (RD_ACK) begin acks.push_back(1); check("rd_ack_with_en", 32'(RD_EN), 32'h1); end
    end
    check("rr_grant_count", 32'(acks.size()), 32'd8);
    for (int i = 0; i < acks.size(); i++) check("rr_order", 32'(acks[i]), 32'(i % 2));

    // Long write starves refresh: overrun at the second wrap, sticky, refresh next
    do_reset();
    INIT_DONE = 1; auto_done = 1; auto_req = 1; dly_wr = 1600; WR_REQ = 1;
    repeat (1559) tick();
    check("ovr_before_2nd_wrap", 32'(REF_OVERRUN), 32'h0);
    tick();
    check("ovr_at_2nd_wrap", 32'(REF_OVERRUN), 32'h1);
    for (int i = 0; i < 100 && WR_EN; i++) tick();
    check("long_wr_done", 32'(WR_EN), 32'h0);
    tick();
    check("ref_after_long_wr", 32'({REF_EN, REF_OVERRUN}), 32'b11);
    repeat (10) tick();
    check("ovr_sticky", 32'(REF_OVERRUN), 32'h1);

    // Asynchronous reset mid-write, then fresh refresh timing
    do_reset();
    INIT_DONE = 1; auto_done = 1; auto_req = 1; dly_wr = 50; WR_REQ = 1;
    repeat (3) tick();
    check("wr_in_flight", 32'(WR_EN), 32'h1);
    #2 RST = 1;
    model_reset();
    #1 check("async_reset", 32'(outs), 32'h0);
    @(negedge REF_CLK);
    RST = 0; WR_REQ = 0; cyc = 0;
    first_rise = -1;
    repeat (790) begin
      pr = REF_EN;
      tick();
      if (REF_EN && !pr && first_rise < 0) first_rise = cyc;
    end
    check("post_reset_first_ref", 32'(first_rise), 32'd781);

    // Random traffic
    do_reset();
    INIT_DONE = 1; auto_done = 1; auto_req = 1; noise = 1;
    repeat (6000) begin
      if (m_op == 0) begin
        dly_ref = $urandom_range(1, 6);
        dly_wr  = ($urandom_range(0, 49) == 0) ? 900 : $urandom_range(1, 8);
        dly_rd  = $urandom_range(1, 8);
      end
      if (!WR_REQ && $urandom_range(0, 7) == 0) WR_REQ = 1;
      if (!RD_REQ && $urandom_range(0, 7) == 0) RD_REQ = 1;
      if (WR_REQ && $urandom_range(0, 63) == 0) WR_REQ = 0;
      if (RD_REQ && $urandom_range(0, 63) == 0) RD_REQ = 0;
      if ($urandom_range(0, 999) == 0) INIT_DONE = ~INIT_DONE;
      tick();
      check("en_onehot0", 32'($countones({REF_EN, WR_EN, RD_EN}) <= 1), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
